// File: rtl/pio_shift_pkg.sv
// Shared types and helpers for the PIO ISR/OSR shift unit.
package pio_shift_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } push_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Shift amounts and thresholds encode WIDTH as 0.
  function automatic int eff(input int value, input int width);
    return (value == 0) ? width : value;
  endfunction

  function automatic int sat_add(input int count, input int n, input int width);
    return (count + n > width) ? width : count + n;
  endfunction

endpackage

// File: rtl/pio_barrel_shift.sv
// Combinational variable shifter: next register value plus the bits shifted out.
module pio_barrel_shift
  import pio_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] fill_i,
  input  logic [CW-1:0]    n_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o,
  output logic [WIDTH-1:0] out_o
);

  localparam logic [CW-1:0] W_C = CW'(WIDTH);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] low_fill;
  logic [CW-1:0]    rem;

  // n_i == WIDTH shifts the all-ones vector out entirely, giving a full mask.
  assign mask     = ~({WIDTH{1'b1}} << n_i);
  assign low_fill = fill_i & mask;
  assign rem      = W_C - n_i;

  always_comb begin
    if (dir_i == DIR_RIGHT) begin
      next_o = (src_i >> n_i) | (low_fill << rem);
      out_o  = src_i & mask;
    end else begin
      next_o = (src_i << n_i) | low_fill;
      out_o  = src_i >> rem;
    end
  end

endmodule

// File: rtl/pio_shift_unit.sv
// PIO shift register usable as ISR (shift-in, autopush) or OSR (shift-out, autopull).
module pio_shift_unit
  import pio_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit IS_OUT = 1'b0,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             penable,
  input  logic             dir,
  input  logic             auto_en,
  input  logic [CW-1:0]    threshold,
  input  logic             shift_req,
  input  logic [CW-1:0]    shift_amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             set_req,
  input  logic [WIDTH-1:0] set_data,
  input  logic             xfer_req,
  input  logic             xfer_block,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_wvalid,
  input  logic             fifo_wready,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_rvalid,
  output logic             fifo_rready,
  output logic             stall,
  output logic [CW-1:0]    shift_count,
  output logic [WIDTH-1:0] data
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  push_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CW-1:0]    n_amt, t_amt, count_sat;
  logic             auto_pull;
  logic [WIDTH-1:0] bs_src, bs_fill, bs_next, bs_out;

  assign n_amt     = CW'(eff(int'(shift_amt), WIDTH));
  assign t_amt     = CW'(eff(int'(threshold), WIDTH));
  assign count_sat = CW'(sat_add(int'(count_q), int'(n_amt), WIDTH));

  // OSR that has reached its threshold shifts straight out of the FIFO word.
  assign auto_pull = IS_OUT && auto_en && (count_q >= t_amt);
  assign bs_src    = auto_pull ? fifo_rdata : data_q;
  assign bs_fill   = IS_OUT ? '0 : din;

  pio_barrel_shift #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shift (
    .src_i  (bs_src),
    .fill_i (bs_fill),
    .n_i    (n_amt),
    .dir_i  (dir),
    .next_o (bs_next),
    .out_o  (bs_out)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    count_d     = count_q;
    fifo_wvalid = 1'b0;
    fifo_rready = 1'b0;
    stall       = 1'b0;
    dout        = '0;
    if (penable && !reset) begin
      if (!IS_OUT) begin
        if (state_q == ST_PUSH) begin
          fifo_wvalid = 1'b1;
          if (fifo_wready) begin
            data_d  = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end
          if (set_req) begin
            data_d  = set_data;
            count_d = '0;
          end else if (xfer_req || shift_req) begin
            stall = 1'b1;
          end
        end else if (set_req) begin
          data_d  = set_data;
          count_d = '0;
        end else if (xfer_req) begin
          if (xfer_block) begin
            state_d = ST_PUSH;
          end else begin
            fifo_wvalid = fifo_wready;
            data_d      = '0;
            count_d     = '0;
          end
        end else if (shift_req) begin
          data_d  = bs_next;
          count_d = count_sat;
          if (auto_en && (count_sat >= t_amt)) state_d = ST_PUSH;
        end
      end else begin
        if (set_req) begin
          data_d  = set_data;
          count_d = '0;
        end else if (xfer_req) begin
          if (fifo_rvalid) begin
            data_d      = fifo_rdata;
            count_d     = '0;
            fifo_rready = 1'b1;
          end else if (xfer_block) begin
            stall = 1'b1;
          end else begin
            count_d = '0;
          end
        end else if (shift_req) begin
          if (auto_pull && !fifo_rvalid) begin
            stall = 1'b1;
          end else begin
            fifo_rready = auto_pull;
            data_d      = bs_next;
            dout        = bs_out;
            count_d     = auto_pull ? n_amt : count_sat;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= IS_OUT ? FULL : '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign fifo_wdata  = IS_OUT ? '0 : data_q;
  assign shift_count = count_q;
  assign data        = data_q;

endmodule

// File: tb/tb_pio_shift_unit.sv
// Bench: ISR and OSR instances on shared stimulus, checked every cycle against a bit-level model.
module tb_pio_shift_unit;

  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, penable = 1'b1, dir = 1'b1, auto_en = 1'b0;
  logic          shift_req = 1'b0, set_req = 1'b0, xfer_req = 1'b0, xfer_block = 1'b0;
  logic          fifo_wready = 1'b1, fifo_rvalid = 1'b0;
  logic [CW-1:0] threshold = '0, shift_amt = '0;
  logic [W-1:0]  din = '0, set_data = '0, fifo_rdata = '0;

  logic [W-1:0]  i_dout, i_wdata, i_data, o_dout, o_wdata, o_data;
  logic          i_wvalid, i_rready, i_stall, o_wvalid, o_rready, o_stall;
  logic [CW-1:0] i_count, o_count;

  pio_shift_unit #(.WIDTH(W), .IS_OUT(1'b0)) u_isr (
    .clk(clk), .reset(reset), .penable(penable), .dir(dir), .auto_en(auto_en),
    .threshold(threshold), .shift_req(shift_req), .shift_amt(shift_amt), .din(din),
    .dout(i_dout), .set_req(set_req), .set_data(set_data), .xfer_req(xfer_req),
    .xfer_block(xfer_block), .fifo_wdata(i_wdata), .fifo_wvalid(i_wvalid),
    .fifo_wready(fifo_wready), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
    .fifo_rready(i_rready), .stall(i_stall), .shift_count(i_count), .data(i_data)
  );

  pio_shift_unit #(.WIDTH(W), .IS_OUT(1'b1)) u_osr (
    .clk(clk), .reset(reset), .penable(penable), .dir(dir), .auto_en(auto_en),
    .threshold(threshold), .shift_req(shift_req), .shift_amt(shift_amt), .din(din),
    .dout(o_dout), .set_req(set_req), .set_data(set_data), .xfer_req(xfer_req),
    .xfer_block(xfer_block), .fifo_wdata(o_wdata), .fifo_wvalid(o_wvalid),
    .fifo_wready(fifo_wready), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
    .fifo_rready(o_rready), .stall(o_stall), .shift_count(o_count), .data(o_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int effv(input int v);
    return (v == 0) ? W : v;
  endfunction

  function automatic int minw(input int a);
    return (a > W) ? W : a;
  endfunction

  // Model state
  logic [W-1:0] mi_data, mo_data;
  int           mi_count, mo_count;
  bit           mi_push;

  task automatic model_isr();
    int           n = effv(int'(shift_amt));
    int           t = effv(int'(threshold));
    bit           ev = 1'b0, es = 1'b0, np = mi_push;
    logic [W-1:0] nd = mi_data;
    int           nc = mi_count;
    if (penable) begin
      if (mi_push) begin
        ev = 1'b1;
        if (fifo_wready) begin nd = '0; nc = 0; np = 1'b0; end
        if (set_req) begin nd = set_data; nc = 0; end
        else if (shift_req || xfer_req) es = 1'b1;
      end else if (set_req) begin
        nd = set_data; nc = 0;
      end else if (xfer_req) begin
        if (xfer_block) np = 1'b1;
        else begin ev = fifo_wready; nd = '0; nc = 0; end
      end else if (shift_req) begin
        if (dir) for (int i = 0; i < n; i++) nd = {din[i], nd[W-1:1]};
        else     for (int i = n - 1; i >= 0; i--) nd = {nd[W-2:0], din[i]};
        nc = minw(mi_count + n);
        if (auto_en && nc >= t) np = 1'b1;
      end
    end
    chk("isr_wvalid", 64'(i_wvalid), 64'(ev));
    if (ev) chk("isr_wdata", 64'(i_wdata), 64'(mi_data));
    chk("isr_stall", 64'(i_stall), 64'(es));
    chk("isr_rready", 64'(i_rready), 64'(0));
    chk("isr_dout", 64'(i_dout), 64'(0));
    chk("isr_count", 64'(i_count), 64'(mi_count));
    chk("isr_data", 64'(i_data), 64'(mi_data));
    mi_data = nd; mi_count = nc; mi_push = np;
  endtask

  task automatic model_osr();
    int           n = effv(int'(shift_amt));
    int           t = effv(int'(threshold));
    bit           er = 1'b0, es = 1'b0, pull;
    logic [W-1:0] ed = '0, nd = mo_data, src;
    int           nc = mo_count;
    if (penable) begin
      if (set_req) begin
        nd = set_data; nc = 0;
      end else if (xfer_req) begin
        if (fifo_rvalid) begin nd = fifo_rdata; nc = 0; er = 1'b1; end
        else if (xfer_block) es = 1'b1;
        else nc = 0;
      end else if (shift_req) begin
        pull = auto_en && (mo_count >= t);
        if (pull && !fifo_rvalid) es = 1'b1;
        else begin
          src = pull ? fifo_rdata : mo_data;
          er  = pull;
          for (int i = 0; i < n; i++) begin
            if (dir) begin ed[i] = src[0]; src = src >> 1; end
            else begin ed = {ed[W-2:0], src[W-1]}; src = src << 1; end
          end
          nd = src;
          nc = pull ? n : minw(mo_count + n);
        end
      end
    end
    chk("osr_rready", 64'(o_rready), 64'(er));
    chk("osr_stall", 64'(o_stall), 64'(es));
    chk("osr_dout", 64'(o_dout), 64'(ed));
    chk("osr_wvalid", 64'(o_wvalid), 64'(0));
    chk("osr_wdata", 64'(o_wdata), 64'(0));
    chk("osr_count", 64'(o_count), 64'(mo_count));
    chk("osr_data", 64'(o_data), 64'(mo_data));
    mo_data = nd; mo_count = nc;
  endtask

  // Single compare process: inputs for the coming edge are stable at negedge.
  always @(negedge clk) begin
    if (reset) begin
      mi_data = '0; mi_count = 0; mi_push = 1'b0;
      mo_data = '0; mo_count = W;
    end else begin
      model_isr();
      model_osr();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    shift_req = 1'b0; set_req = 1'b0; xfer_req = 1'b0; xfer_block = 1'b0;
  endtask

  task automatic do_reset();
    idle_reqs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    ctl;   // {set, xfer, blk, shift, rvalid, wready, dir, auto_en}
    logic [CW-1:0] amt;
    logic [CW-1:0] thr;
    logic [W-1:0]  d;
  } vec_t;

  vec_t tbl [13] = '{
    '{8'b1000_0100, 6'd0, 6'd0,  32'h0F0F0F0F},
    '{8'b0001_0100, 6'd8, 6'd0,  32'h000000AB},
    '{8'b0100_0100, 6'd0, 6'd0,  32'h00000000},
    '{8'b0110_0000, 6'd0, 6'd0,  32'h00000000},
    '{8'b0001_0000, 6'd8, 6'd0,  32'h00000000},
    '{8'b1001_0000, 6'd8, 6'd0,  32'h11223344},
    '{8'b0000_0100, 6'd0, 6'd0,  32'h00000000},
    '{8'b0001_0000, 6'd8, 6'd0,  32'h00000077},
    '{8'b0100_0000, 6'd0, 6'd0,  32'h00000000},
    '{8'b0100_1100, 6'd0, 6'd0,  32'h89ABCDEF},
    '{8'b0001_1111, 6'd0, 6'd16, 32'hCAFEBABE},
    '{8'b0000_0100, 6'd0, 6'd16, 32'h00000000},
    '{8'b0001_1111, 6'd5, 6'd0,  32'hFFFFFFFF}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    chk("rst_isr_count", 64'(i_count), 64'(0));
    chk("rst_isr_data", 64'(i_data), 64'(0));
    chk("rst_osr_count", 64'(o_count), 64'(32));
    chk("rst_osr_data", 64'(o_data), 64'(0));

    // ISR autopush at threshold 8 with FIFO ready
    dir = 1'b1; threshold = CW'(8); auto_en = 1'b1; fifo_wready = 1'b1;
    shift_amt = CW'(4); shift_req = 1'b1; din = 32'hA;
    cyc();
    din = 32'h5;
    cyc();
    shift_req = 1'b0;
    #1;
    chk("t1_wvalid", 64'(i_wvalid), 64'(1));
    chk("t1_wdata", 64'(i_wdata), 64'h5A000000);
    chk("t1_model_data", 64'(mi_data), 64'h5A000000);
    cyc();
    chk("t1_count_after", 64'(i_count), 64'(0));
    chk("t1_data_after", 64'(i_data), 64'(0));

    // ISR autopush held off by a full FIFO
    do_reset();
    fifo_wready = 1'b0; shift_req = 1'b1; din = 32'hA;
    cyc();
    din = 32'h5;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_stall", 64'(i_stall), 64'(1));
      chk("t2_wdata", 64'(i_wdata), 64'h5A000000);
      chk("t2_count", 64'(i_count), 64'(8));
      cyc();
    end
    shift_req = 1'b0; fifo_wready = 1'b1;
    #1;
    chk("t2_wvalid", 64'(i_wvalid), 64'(1));
    cyc();
    chk("t2_wvalid_after", 64'(i_wvalid), 64'(0));
    chk("t2_count_after", 64'(i_count), 64'(0));

    // OSR autopull on the first shift after reset
    do_reset();
    auto_en = 1'b1; threshold = '0; dir = 1'b0; fifo_rvalid = 1'b1;
    fifo_rdata = 32'h12345678; shift_amt = CW'(8); shift_req = 1'b1;
    #1;
    chk("t3_rready", 64'(o_rready), 64'(1));
    chk("t3_dout", 64'(o_dout), 64'h12);
    cyc();
    shift_req = 1'b0; fifo_rvalid = 1'b0;
    chk("t3_data", 64'(o_data), 64'h34567800);
    chk("t3_count", 64'(o_count), 64'(8));
    chk("t3_model_data", 64'(mo_data), 64'h34567800);

    // OSR stall on empty FIFO, then proceed
    do_reset();
    dir = 1'b1; shift_req = 1'b1;
    #1;
    chk("t4_stall", 64'(o_stall), 64'(1));
    cyc();
    chk("t4_count_held", 64'(o_count), 64'(32));
    chk("t4_data_held", 64'(o_data), 64'(0));
    fifo_rvalid = 1'b1; fifo_rdata = 32'hCAFEF00D;
    #1;
    chk("t4_dout", 64'(o_dout), 64'h0D);
    cyc();
    shift_req = 1'b0; fifo_rvalid = 1'b0;
    chk("t4_data", 64'(o_data), 64'h00CAFEF0);
    chk("t4_count", 64'(o_count), 64'(8));

    // ISR count saturation and full-width load
    do_reset();
    auto_en = 1'b0; dir = 1'b1; shift_amt = CW'(15); shift_req = 1'b1;
    cyc();
    cyc();
    chk("t5_count30", 64'(i_count), 64'(30));
    shift_amt = CW'(4);
    cyc();
    chk("t5_count_sat", 64'(i_count), 64'(32));
    shift_amt = '0; din = 32'hDEADBEEF;
    cyc();
    shift_req = 1'b0;
    chk("t5_data", 64'(i_data), 64'hDEADBEEF);
    chk("t5_model_count", 64'(mi_count), 64'(32));

    // penable low freezes everything
    penable = 1'b0; shift_req = 1'b1; shift_amt = CW'(4); din = 32'h1;
    repeat (3) cyc();
    chk("t6_frozen_data", 64'(i_data), 64'hDEADBEEF);
    chk("t6_frozen_count", 64'(i_count), 64'(32));
    penable = 1'b1; shift_req = 1'b0;

    // Reset while a push is pending
    auto_en = 1'b1; threshold = CW'(4); fifo_wready = 1'b0; shift_req = 1'b1;
    cyc();
    shift_req = 1'b0;
    #1;
    chk("t6_push_pending", 64'(i_wvalid), 64'(1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_wvalid_after_rst", 64'(i_wvalid), 64'(0));
    chk("t6_count_after_rst", 64'(i_count), 64'(0));

    // Directed set / xfer / priority sequence
    do_reset();
    for (int k = 0; k < 13; k++) begin
      {set_req, xfer_req, xfer_block, shift_req, fifo_rvalid, fifo_wready, dir, auto_en} = tbl[k].ctl;
      shift_amt = tbl[k].amt;
      threshold = tbl[k].thr;
      din = tbl[k].d; set_data = tbl[k].d; fifo_rdata = tbl[k].d;
      cyc();
    end
    idle_reqs(); fifo_rvalid = 1'b0;
    chk("t7_osr_data", 64'(o_data), 64'h07FFFFFF);
    chk("t7_osr_count", 64'(o_count), 64'(5));
    chk("t7_isr_data", 64'(i_data), 64'hF8000000);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
